cla_pipe_addsub: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
- Each group computes per-bit generate/propagate and the lookahead carries c1, c2, c3, co from its group carry-in.
- The WIDTH/4 groups are split evenly across STAGES register stages, and group carries ripple between groups inside a stage.
- A valid/ready handshake on both sides lets it sit between datapath registers in the ALU.

---
 rtl/cla_pipe_addsub.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups.
// Define CLA_FLAGS_EN to add the registered zero (zf) and negative (nf) flag outputs.
module cla_pipe_addsub #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
`ifdef CLA_FLAGS_EN
    ,
    output logic             zf,
    output logic             nf
`endif
);

    localparam int unsigned G  = WIDTH / (4 * STAGES);
    localparam int unsigned AW = $clog2(WIDTH);

    // Per-stage inputs: index 0 is the conditioned operand set, k>0 the registers of stage k-1.
    logic [WIDTH-1:0] st_a [STAGES];
    logic [WIDTH-1:0] st_b [STAGES];
    logic [WIDTH-1:0] st_s [STAGES];
    logic             st_c [STAGES];
    logic             st_v [STAGES];
    logic             st_o [STAGES];

    logic [WIDTH-1:0] s_q;
    logic             co_q;
    logic             ovf_q;
    logic             out_valid_q;
    logic             stall;

    // Returns {carry into bit 3, carry out, sum[3:0]} of one lookahead group.
    function automatic logic [5:0] cla4(input logic [3:0] x, input logic [3:0] y,
                                        input logic cin);
        logic [3:0] g;
        logic [3:0] p;
        logic       c1, c2, c3, c4;
        g  = x & y;
        p  = x ^ y;
        c1 = g[0] | (p[0] & cin);
        c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
        c4 = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
           | (p[3] & p[2] & p[1] & p[0] & cin);
        return {c3, c4, p ^ {c3, c2, c1, cin}};
    endfunction

    assign stall    = out_valid_q & ~out_ready;
    assign in_ready = ~stall;

    assign st_a[0] = a;
    assign st_b[0] = sub ? ~b : b;
    assign st_s[0] = '0;
    assign st_c[0] = sub ? 1'b1 : ci;
    assign st_v[0] = in_valid & ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] s_d;
        logic             c_d;
        logic             m_d;
        logic [5:0]       r;

        // Ripple group carries across this stage's slice of groups.
        always_comb begin
            s_d = st_s[k];
            c_d = st_c[k];
            m_d = 1'b0;
            r   = '0;
            for (int unsigned gi = 0; gi < G; gi++) begin
                r = cla4(st_a[k][AW'((k * G + gi) * 4) +: 4],
                         st_b[k][AW'((k * G + gi) * 4) +: 4], c_d);
                s_d[AW'((k * G + gi) * 4) +: 4] = r[3:0];
                m_d = r[5];
                c_d = r[4];
            end
        end

        assign st_o[k] = m_d ^ c_d;

        if (k == STAGES - 1) begin : g_last
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    out_valid_q <= 1'b0;
                    s_q         <= '0;
                    co_q        <= 1'b0;
                    ovf_q       <= 1'b0;
`ifdef CLA_FLAGS_EN
                    zf          <= 1'b0;
                    nf          <= 1'b0;
`endif
                end else if (!stall) begin
                    out_valid_q <= st_v[k];
                    s_q         <= s_d;
                    co_q        <= c_d;
                    ovf_q       <= st_o[k];
`ifdef CLA_FLAGS_EN
                    zf          <= (s_d == '0);
                    nf          <= s_d[WIDTH-1];
`endif
                end
            end
        end else begin : g_mid
            logic [WIDTH-1:0] a_q;
            logic [WIDTH-1:0] b_q;
            logic [WIDTH-1:0] s_q;
            logic             c_q;
            logic             v_q;

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    a_q <= '0;
                    b_q <= '0;
                    s_q <= '0;
                    c_q <= 1'b0;
                    v_q <= 1'b0;
                end else if (!stall) begin
                    a_q <= st_a[k];
                    b_q <= st_b[k];
                    s_q <= s_d;
                    c_q <= c_d;
                    v_q <= st_v[k];
                end
            end

            assign st_a[k+1] = a_q;
            assign st_b[k+1] = b_q;
            assign st_s[k+1] = s_q;
            assign st_c[k+1] = c_q;
            assign st_v[k+1] = v_q;
        end
    end

    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign co        = co_q;
    assign ovf       = ovf_q;

endmodule
